// File: rtl/gpv_change_capture.sv
// Change logger for the general-purpose vector bus: masked bit changes are
// stamped and queued in a first-word-fall-through FIFO drained over valid/ready.
module gpv_change_capture #(
  parameter int VECTOR_WIDTH = 64,
  parameter int DEPTH        = 8,
  parameter int TS_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [VECTOR_WIDTH-1:0]    vector,
  input  logic [VECTOR_WIDTH-1:0]    mask,
  input  logic                       enable,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_WIDTH-1:0]        out_ts,
  output logic [VECTOR_WIDTH-1:0]    out_value,
  output logic [VECTOR_WIDTH-1:0]    out_changed,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic [15:0]                drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t                   state, state_nxt;
  logic [VECTOR_WIDTH-1:0]  prev_p0;
  logic [VECTOR_WIDTH-1:0]  diff;
  logic [TS_WIDTH-1:0]      ts;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [LW-1:0]            level_r;
  logic [15:0]              drop_r;
  logic                     push_req, load_prev, pop, push_ok, drop_ev;

  logic [TS_WIDTH-1:0]      mem_ts  [DEPTH];
  logic [VECTOR_WIDTH-1:0]  mem_val [DEPTH];
  logic [VECTOR_WIDTH-1:0]  mem_chg [DEPTH];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: compare the live vector against the last sample
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    load_prev = 1'b0;
    diff      = (vector ^ prev_p0) & mask;
    case (state)
      IDLE: if (enable) state_nxt = ARM;
      ARM: begin
        load_prev = 1'b1;
        state_nxt = enable ? RUN : IDLE;
      end
      RUN: begin
        if (enable) begin
          load_prev = 1'b1;
          push_req  = |diff;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign full      = (level_r == LW'(DEPTH));
  assign out_valid = (level_r != '0);
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push_ok   = push_req && (!full || pop);
  assign drop_ev   = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      prev_p0 <= '0;
      ts      <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
      drop_r  <= '0;
    end else begin
      state <= state_nxt;
      ts    <= ts + TS_WIDTH'(1);
      if (load_prev) prev_p0 <= vector;
      if (push_ok)   wr_ptr  <= wr_ptr + PW'(1);
      if (pop)       rd_ptr  <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
      if (drop_ev) drop_r <= sat_inc16(drop_r);
    end
  end

  // Stage p1: FIFO storage, head read straight from the read pointer
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_ts[wr_ptr]  <= ts;
      mem_val[wr_ptr] <= vector;
      mem_chg[wr_ptr] <= diff;
    end
  end

  assign out_ts      = out_valid ? mem_ts[rd_ptr]  : '0;
  assign out_value   = out_valid ? mem_val[rd_ptr] : '0;
  assign out_changed = out_valid ? mem_chg[rd_ptr] : '0;
  assign level       = level_r;
  assign drop_cnt    = drop_r;

endmodule
